// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch from a 1-cycle-latency
// program memory, PC-tagged instruction queue, valid/ready delivery to decode
// and redirect with squash of stale responses.
module fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [29:0] RESET_PC = 30'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_re,
   output logic [29:0] memaddr,
   input  logic [31:0] rmemdata,
   input  logic        mem_gnt,
   input  logic        redirect,
   input  logic [29:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [29:0] inst_pc,
   input  logic        inst_ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 30 + 32;

   logic [29:0]      fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic [29:0]      tag_q, tag_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ENT_W-1:0] buf_q [DEPTH];
   logic             push;
   logic             pop;

   // Issue a read only when a queue slot is free for its response
   always_comb begin
      mem_re  = !rst && !redirect && mem_gnt
                && ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
      memaddr = fetch_pc_q;
   end

   // Queue head presented to decode
   always_comb begin
      inst_valid       = (count_q != '0);
      {inst_pc, inst}  = buf_q[rd_ptr_q];
   end

   // Next-state: issue, push/pop bookkeeping, redirect overrides all
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = 1'b0;
      tag_d      = tag_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      push       = inflight_q && !redirect;
      pop        = inst_valid && inst_ready && !redirect;

      if (mem_re) begin
         fetch_pc_d = fetch_pc_q + 30'd1;
         inflight_d = 1'b1;
         tag_d      = fetch_pc_q;
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         tag_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage; contents are only meaningful below count, so no reset
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         buf_q[wr_ptr_q] <= {tag_q, rmemdata};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (pc, inst)
// pairs, independent monitors pop and compare on each accepted delivery.
module tb_fetch_unit;

   typedef struct packed {
      logic [29:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, mem_gnt, redirect, inst_ready;
   logic [29:0] redirect_pc;
   logic        mem_re, inst_valid;
   logic [29:0] memaddr, inst_pc;
   logic [31:0] rmemdata, inst;

   logic        rst_w;
   logic        mem_re_w, inst_valid_w;
   logic [29:0] memaddr_w, inst_pc_w;
   logic [31:0] rmemdata_w, inst_w;

   exp_t sb[$];
   exp_t sb_w[$];
   exp_t mon_e, mon_w_e;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(4), .RESET_PC(30'h0)) dut (
      .clk(clk), .rst(rst), .mem_re(mem_re), .memaddr(memaddr),
      .rmemdata(rmemdata), .mem_gnt(mem_gnt), .redirect(redirect),
      .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
      .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   fetch_unit #(.DEPTH(4), .RESET_PC(30'h3FFF_FFFF)) dut_w (
      .clk(clk), .rst(rst_w), .mem_re(mem_re_w), .memaddr(memaddr_w),
      .rmemdata(rmemdata_w), .mem_gnt(1'b1), .redirect(1'b0),
      .redirect_pc(30'h0), .inst_valid(inst_valid_w), .inst(inst_w),
      .inst_pc(inst_pc_w), .inst_ready(1'b1)
   );

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return 32'hA000_0000 + {2'b00, a};
   endfunction

   // Program memory models: one-cycle read latency, junk when not read
   always @(posedge clk) begin
      rmemdata   <= mem_re   ? mem_word(memaddr)   : 32'hDEAD_BEEF;
      rmemdata_w <= mem_re_w ? mem_word(memaddr_w) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [29:0] pc0, input int n);
      logic [29:0] p;
      for (int i = 0; i < n; i++) begin
         p = pc0 + 30'(i);
         sb.push_back('{pc: p, data: mem_word(p)});
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // Wait (bounded) until the monitor has consumed every expected entry
   task automatic wait_drain(input string name, input int bound);
      int k = 0;
      while (sb.size() != 0 && k < bound) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   // Monitor for the main instance: every accepted head must match the scoreboard
   always @(negedge clk) begin
      if (!rst && !redirect && inst_valid && inst_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery: got pc %h inst %h, required none", inst_pc, inst);
         end else begin
            mon_e = sb.pop_front();
            chk("deliver_pc", 32'(inst_pc), 32'(mon_e.pc));
            chk("deliver_inst", inst, mon_e.data);
         end
      end
   end

   // Monitor for the wrap instance: first deliveries after reset only
   always @(negedge clk) begin
      if (!rst_w && inst_valid_w && sb_w.size() != 0) begin
         mon_w_e = sb_w.pop_front();
         chk("wrap_pc", 32'(inst_pc_w), 32'(mon_w_e.pc));
         chk("wrap_inst", inst_w, mon_w_e.data);
      end
   end

   // Wrap instance: RESET_PC at the top of the address space
   initial begin
      rst_w = 1'b1;
      sb_w.push_back('{pc: 30'h3FFF_FFFF, data: 32'hDFFF_FFFF});
      sb_w.push_back('{pc: 30'h0000_0000, data: 32'hA000_0000});
      sb_w.push_back('{pc: 30'h0000_0001, data: 32'hA000_0001});
      repeat (2) @(posedge clk);
      #1;
      rst_w = 1'b0;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; inst_ready = 1'b1; mem_gnt = 1'b1;
      redirect = 1'b0; redirect_pc = 30'h0;

      // Reset state
      cyc();
      samp();
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);

      // Streaming from RESET_PC, one instruction per cycle after 2-cycle startup
      push_exp(30'h0, 8);
      cyc(); rst = 1'b0;
      samp();
      chk("c0_mem_re", 32'(mem_re), 32'd1);
      chk("c0_memaddr", 32'(memaddr), 32'd0);
      chk("c0_inst_valid", 32'(inst_valid), 32'd0);
      cyc(); samp();
      chk("c1_memaddr", 32'(memaddr), 32'd1);
      chk("c1_inst_valid", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(); samp();
         chk("stream_valid", 32'(inst_valid), 32'd1);
      end
      cyc(); inst_ready = 1'b0;
      chk("stream_drained", 32'(sb.size()), 32'd0);

      // Reset with buffered entries and a response inflight
      cyc(); rst = 1'b1;
      samp();
      chk("rst_mid_mem_re", 32'(mem_re), 32'd0);
      cyc(); rst = 1'b0;
      samp();
      chk("post_rst_valid", 32'(inst_valid), 32'd0);

      // Back-pressure: exactly DEPTH requests, then fetch stalls
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin cyc(); samp(); end
         chk("bp_mem_re", 32'(mem_re), (i < 4) ? 32'd1 : 32'd0);
         if (i < 4) chk("bp_memaddr", 32'(memaddr), 32'(i));
      end
      chk("bp_full_valid", 32'(inst_valid), 32'd1);
      cyc(); inst_ready = 1'b1;
      push_exp(30'h0, 8);
      wait_drain("bp_drain", 30);
      cyc(); inst_ready = 1'b0;

      // Redirect with 3 queued entries and one inflight
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      repeat (4) cyc();
      redirect = 1'b1; redirect_pc = 30'h40; inst_ready = 1'b1;
      samp();
      chk("redir_mem_re", 32'(mem_re), 32'd0);
      cyc(); redirect = 1'b0;
      samp();
      chk("redir_valid", 32'(inst_valid), 32'd0);
      chk("redir_mem_re1", 32'(mem_re), 32'd1);
      chk("redir_memaddr", 32'(memaddr), 32'h40);
      push_exp(30'h40, 6);
      wait_drain("redir_drain", 30);
      cyc(); inst_ready = 1'b0;

      // Back-to-back redirects: the last one wins
      cyc(); redirect = 1'b1; redirect_pc = 30'h100; inst_ready = 1'b1;
      cyc(); redirect_pc = 30'h200;
      cyc(); redirect = 1'b0;
      samp();
      chk("b2b_valid", 32'(inst_valid), 32'd0);
      chk("b2b_memaddr", 32'(memaddr), 32'h200);
      push_exp(30'h200, 4);
      wait_drain("b2b_drain", 30);
      cyc(); inst_ready = 1'b0;

      // Grant toggling: requests only in granted cycles, PCs stay contiguous
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0; inst_ready = 1'b1;
      push_exp(30'h0, 5);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         mem_gnt = (i % 2 == 0);
         samp();
         chk("gnt_mem_re", 32'(mem_re), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      cyc(); mem_gnt = 1'b0;
      wait_drain("gnt_drain", 30);

      chk("wrap_drained", 32'(sb_w.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
